// File: rtl/b2r_pingpong_converter_pkg.sv
// rtl/b2r_pingpong_converter_pkg.sv - shared types and helpers for the block-to-row converter
package b2r_pingpong_converter_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    // Counter width that never collapses to zero bits for single-entry ranges.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/b2r_band_buffer.sv
// rtl/b2r_band_buffer.sv - one ROWxCOL band of element storage, block write / chunk read
module b2r_band_buffer
    import b2r_pingpong_converter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BLOCK_SIZE  = 2,
    parameter int CHUNK_SIZE  = 4,
    parameter int NUM_CORES_H = 4,
    parameter int NUM_CORES_V = 2,
    localparam int ROW = NUM_CORES_V * BLOCK_SIZE,
    localparam int COL = NUM_CORES_H * BLOCK_SIZE,
    localparam int CPR = COL / CHUNK_SIZE,
    localparam int BCW = cnt_w(NUM_CORES_H),
    localparam int BRW = cnt_w(NUM_CORES_V),
    localparam int RW  = cnt_w(ROW),
    localparam int CW  = cnt_w(CPR)
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [BRW-1:0]                       wr_br,
    input  logic [BCW-1:0]                       wr_bc,
    input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] wr_data,
    input  logic [RW-1:0]                        rd_row,
    input  logic [CW-1:0]                        rd_ch,
    output logic [CHUNK_SIZE*WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem_q [ROW][COL];
    logic [WIDTH-1:0] mem_d [ROW][COL];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                for (int c = 0; c < BLOCK_SIZE; c++) begin
                    mem_d[int'(wr_br)*BLOCK_SIZE + r][int'(wr_bc)*BLOCK_SIZE + c] =
                        wr_data[(r*BLOCK_SIZE + c)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by the bank state in the top.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < CHUNK_SIZE; k++) begin
            rd_data[k*WIDTH +: WIDTH] = mem_q[rd_row][int'(rd_ch)*CHUNK_SIZE + k];
        end
    end

endmodule

// File: rtl/b2r_pingpong_converter.sv
// rtl/b2r_pingpong_converter.sv - ping-pong block-to-row reorder between score matmul and softmax
module b2r_pingpong_converter
    import b2r_pingpong_converter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int BLOCK_SIZE  = 2,
    parameter int CHUNK_SIZE  = 4,
    parameter int NUM_CORES_H = 4,
    parameter int NUM_CORES_V = 2,
    localparam int ROW = NUM_CORES_V * BLOCK_SIZE,
    localparam int COL = NUM_CORES_H * BLOCK_SIZE,
    localparam int CPR = COL / CHUNK_SIZE,
    localparam int BCW = cnt_w(NUM_CORES_H),
    localparam int BRW = cnt_w(NUM_CORES_V),
    localparam int RW  = cnt_w(ROW),
    localparam int CW  = cnt_w(CPR)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clear,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [CHUNK_SIZE*WIDTH-1:0]            out_data,
    output logic                                   out_row_last,
    output logic                                   out_band_last
);

    if ((COL % CHUNK_SIZE) != 0) begin : g_bad_chunk
        $error("b2r_pingpong_converter: COL must be a multiple of CHUNK_SIZE");
    end

    localparam logic [BCW-1:0] BC_MAX  = BCW'(NUM_CORES_H - 1);
    localparam logic [BRW-1:0] BR_MAX  = BRW'(NUM_CORES_V - 1);
    localparam logic [RW-1:0]  ROW_MAX = RW'(ROW - 1);
    localparam logic [CW-1:0]  CH_MAX  = CW'(CPR - 1);

    bank_state_t    state_q [2];
    bank_state_t    state_d [2];
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [BCW-1:0] wr_bc_q, wr_bc_d;
    logic [BRW-1:0] wr_br_q, wr_br_d;
    logic [RW-1:0]  rd_row_q, rd_row_d;
    logic [CW-1:0]  rd_ch_q, rd_ch_d;

    logic wr_fire, rd_fire, wr_last;
    logic [CHUNK_SIZE*WIDTH-1:0] rd_data [2];

    assign in_ready      = !rst && (state_q[wr_bank_q] == BANK_EMPTY ||
                                    state_q[wr_bank_q] == BANK_FILLING);
    assign out_valid     = state_q[rd_bank_q] == BANK_FULL ||
                           state_q[rd_bank_q] == BANK_DRAINING;
    assign out_row_last  = out_valid && (rd_ch_q == CH_MAX);
    assign out_band_last = out_row_last && (rd_row_q == ROW_MAX);
    assign out_data      = out_valid ? rd_data[rd_bank_q] : '0;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_last = (wr_bc_q == BC_MAX) && (wr_br_q == BR_MAX);

    // Write and read always target different banks, so both updates can land in one cycle.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_bc_d   = wr_bc_q;
        wr_br_d   = wr_br_q;
        rd_row_d  = rd_row_q;
        rd_ch_d   = rd_ch_q;

        if (wr_fire) begin
            if (wr_last) begin
                state_d[wr_bank_q] = BANK_FULL;
                wr_bank_d          = !wr_bank_q;
                wr_bc_d            = '0;
                wr_br_d            = '0;
            end else begin
                state_d[wr_bank_q] = BANK_FILLING;
                if (wr_bc_q == BC_MAX) begin
                    wr_bc_d = '0;
                    wr_br_d = wr_br_q + 1'b1;
                end else begin
                    wr_bc_d = wr_bc_q + 1'b1;
                end
            end
        end

        if (rd_fire) begin
            if (out_band_last) begin
                state_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d          = !rd_bank_q;
                rd_row_d           = '0;
                rd_ch_d            = '0;
            end else begin
                state_d[rd_bank_q] = BANK_DRAINING;
                if (rd_ch_q == CH_MAX) begin
                    rd_ch_d  = '0;
                    rd_row_d = rd_row_q + 1'b1;
                end else begin
                    rd_ch_d = rd_ch_q + 1'b1;
                end
            end
        end

        if (clear) begin
            state_d[0] = BANK_EMPTY;
            state_d[1] = BANK_EMPTY;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_bc_d    = '0;
            wr_br_d    = '0;
            rd_row_d   = '0;
            rd_ch_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_bc_q    <= '0;
            wr_br_q    <= '0;
            rd_row_q   <= '0;
            rd_ch_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_bc_q    <= wr_bc_d;
            wr_br_q    <= wr_br_d;
            rd_row_q   <= rd_row_d;
            rd_ch_q    <= rd_ch_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        b2r_band_buffer #(
            .WIDTH       (WIDTH),
            .BLOCK_SIZE  (BLOCK_SIZE),
            .CHUNK_SIZE  (CHUNK_SIZE),
            .NUM_CORES_H (NUM_CORES_H),
            .NUM_CORES_V (NUM_CORES_V)
        ) u_buf (
            .clk     (clk),
            .we      (wr_fire && (wr_bank_q == 1'(b))),
            .wr_br   (wr_br_q),
            .wr_bc   (wr_bc_q),
            .wr_data (in_data),
            .rd_row  (rd_row_q),
            .rd_ch   (rd_ch_q),
            .rd_data (rd_data[b])
        );
    end

endmodule
